// File: rtl/eac_adder_pipe.sv
// Two-stage pipelined end-around-carry (one's-complement) adder.
// S1 forms per-group sum / sum+1 / generate / propagate; S2 resolves the end-around carry.
module eac_adder_pipe #(
  parameter int WIDTH         = 48,
  parameter int CLA_GRP_WIDTH = 12,
  parameter int TAG_W         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               zero,
  output logic               neg,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int GW   = CLA_GRP_WIDTH;
  localparam int NGRP = WIDTH / CLA_GRP_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and in_ready depends only on stage
  // occupancy and out_ready (never on in_valid).
  logic                      w_s2_adv;
  logic                      w_s1_adv;

  logic [NGRP-1:0][GW-1:0]   w_s;
  logic [NGRP-1:0][GW-1:0]   w_sp1;
  logic [NGRP-1:0]           w_gg;
  logic [NGRP-1:0]           w_gp;

  logic                      r_s1_valid;
  logic [NGRP-1:0][GW-1:0]   r_s;
  logic [NGRP-1:0][GW-1:0]   r_sp1;
  logic [NGRP-1:0]           r_gg;
  logic [NGRP-1:0]           r_gp;
  logic [TAG_W-1:0]          r_s1_tag;

  logic                      w_c;
  logic [WIDTH-1:0]          w_sum;
  logic                      w_zero;

  logic                      r_out_valid;
  logic [WIDTH-1:0]          r_sum;
  logic                      r_zero;
  logic                      r_neg;
  logic [TAG_W-1:0]          r_out_tag;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Stage 1: both candidate sums per group, plus group generate/propagate.
  for (genvar k = 0; k < NGRP; k++) begin : g_s1
    logic [GW:0] w_add0;
    logic [GW:0] w_add1;
    assign w_add0   = {1'b0, a[k*GW +: GW]} + {1'b0, b[k*GW +: GW]};
    assign w_add1   = w_add0 + {{GW{1'b0}}, 1'b1};
    assign w_s[k]   = w_add0[GW-1:0];
    assign w_sp1[k] = w_add1[GW-1:0];
    assign w_gg[k]  = w_add0[GW];
    assign w_gp[k]  = &(a[k*GW +: GW] ^ b[k*GW +: GW]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_s      <= w_s;
      r_sp1    <= w_sp1;
      r_gg     <= w_gg;
      r_gp     <= w_gp;
      r_s1_tag <= in_tag;
    end
  end

  // Stage 2: the word carry-out with carry-in 0 becomes the carry-in of group 0,
  // then the same (GG, GP) prefix selects each group's result.
  always_comb begin
    w_c   = 1'b0;
    w_sum = '0;
    for (int k = 0; k < NGRP; k++) begin
      w_c = r_gg[k] | (r_gp[k] & w_c);
    end
    for (int k = 0; k < NGRP; k++) begin
      w_sum[k*GW +: GW] = w_c ? r_sp1[k] : r_s[k];
      w_c = r_gg[k] | (r_gp[k] & w_c);
    end
  end

  // Negative zero (all ones) is reported as zero but left un-normalised.
  assign w_zero = (&w_sum) | (~|w_sum);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum     <= w_sum;
        r_zero    <= w_zero;
        r_neg     <= w_sum[WIDTH-1];
        r_out_tag <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_eac_adder_pipe.sv
// Bench for eac_adder_pipe: one's-complement reference model with a scoreboard,
// directed literal cases, backpressure, mid-flight reset and randomized traffic.
module tb_eac_adder_pipe;

  localparam int WIDTH = 48;
  localparam int TAG_W = 4;
  localparam int EW    = WIDTH + 2 + TAG_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [WIDTH-1:0]   sum;
  logic               zero;
  logic               neg;
  logic [TAG_W-1:0]   out_tag;

  int checks = 0;
  int failures = 0;

  logic [EW-1:0]    exp_q[$];
  int               stall_q[$];
  int               cyc_q[$];
  logic [TAG_W-1:0] tag_log[$];
  int               stall_cnt = 0;
  int               cyc = 0;
  logic             hold_prev = 1'b0;
  logic [EW-1:0]    out_prev = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  eac_adder_pipe #(.WIDTH(WIDTH), .CLA_GRP_WIDTH(12), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .zero      (zero),
    .neg       (neg),
    .out_tag   (out_tag)
  );

  // Reference: plain 49-bit add, wrap the carry back in once.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic [TAG_W-1:0] t);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] s;
    full = {1'b0, x} + {1'b0, y};
    s    = full[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, full[WIDTH]};
    return {s, (s == '0) || (s == '1), s[WIDTH-1], t};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic [EW-1:0] e;
    int st;
    int ac;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        stall_q.delete();
        cyc_q.delete();
        hold_prev = 1'b0;
      end else begin
        if (hold_prev)
          check("hold_stable", 64'({out_valid, sum, zero, neg, out_tag}), 64'({1'b1, out_prev}));
        check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
        if (out_valid && exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'(1'b0));
        end else if (out_valid && out_ready) begin
          e  = exp_q.pop_front();
          st = stall_q.pop_front();
          ac = cyc_q.pop_front();
          check("result", 64'({sum, zero, neg, out_tag}), 64'(e));
          if (st == stall_cnt) check("latency", 64'(cyc - ac), 64'(2));
          tag_log.push_back(out_tag);
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, in_tag));
          stall_q.push_back(stall_cnt);
          cyc_q.push_back(cyc);
        end
        if (!out_ready) stall_cnt++;
        hold_prev = out_valid && !out_ready;
        out_prev  = {sum, zero, neg, out_tag};
      end
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t,
                          input logic [WIDTH-1:0] es, input logic ez, input logic en);
    send(x, y, t);
    @(negedge clk);
    check("dir_lat_s1", 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    check("dir_lat_s2", 64'(out_valid), 64'(1'b1));
    check("dir_sum", 64'(sum), 64'(es));
    check("dir_flags", 64'({zero, neg, out_tag}), 64'({ez, en, t}));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] xa[3];
    logic [WIDTH-1:0] xb[3];
    logic [63:0] r64;
    int idx;
    int n;
    bit acc;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_flags", 64'({zero, neg, out_tag}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1'b1));

    check("model_pin_ripple", 64'(model(48'h800000000000, 48'h800000000000, 4'h0)), 64'({48'h1, 1'b0, 1'b0, 4'h0}));
    check("model_pin_negzero", 64'(model(48'h5, 48'hFFFFFFFFFFFA, 4'h7)), 64'({48'hFFFFFFFFFFFF, 1'b1, 1'b1, 4'h7}));

    directed(48'h000000000001, 48'h000000000002, 4'd1, 48'h000000000003, 1'b0, 1'b0);
    directed(48'h000000000FFF, 48'h000000000001, 4'd2, 48'h000000001000, 1'b0, 1'b0);
    directed(48'hFFFFFFFFFFFF, 48'h000000000005, 4'd3, 48'h000000000005, 1'b0, 1'b0);
    directed(48'h800000000000, 48'h800000000000, 4'd4, 48'h000000000001, 1'b0, 1'b0);
    directed(48'h000000000005, 48'hFFFFFFFFFFFA, 4'd5, 48'hFFFFFFFFFFFF, 1'b1, 1'b1);

    // Backpressure: three back-to-back ops against a stalled consumer.
    for (int i = 0; i < 3; i++) begin
      r64 = {$urandom(), $urandom()};
      xa[i] = r64[WIDTH-1:0];
      r64 = {$urandom(), $urandom()};
      xb[i] = r64[WIDTH-1:0];
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tag_log.delete();
    idx = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (idx < 3) begin
        in_valid = 1'b1; a = xa[idx]; b = xb[idx]; in_tag = TAG_W'(idx + 1);
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
    end
    check("bp_accepted", 64'(idx), 64'(2));
    check("bp_in_ready_low", 64'(in_ready), 64'(1'b0));
    n = 0;
    while ((idx < 3 || exp_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (idx < 3) begin
        in_valid = 1'b1; a = xa[idx]; b = xb[idx]; in_tag = TAG_W'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      n++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    check("bp_drain_done", 64'(n < 50), 64'(1'b1));
    check("bp_count", 64'(tag_log.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      if (i < tag_log.size()) check("bp_order", 64'(tag_log[i]), 64'(i + 1));

    // Reset with two ops in flight.
    out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      r64 = {$urandom(), $urandom()};
      a = r64[WIDTH-1:0];
      b = ~r64[WIDTH+7:8];
      in_tag = TAG_W'($urandom_range(0, 15));
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'(1'b0));
    directed(48'h123456789ABC, 48'h0FEDCBA98765, 4'd9, 48'h222222222221, 1'b0, 1'b0);

    // Randomized traffic with random backpressure.
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        r64 = {$urandom(), $urandom()};
        a = r64[WIDTH-1:0];
        r64 = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
          0: b = r64[WIDTH-1:0];
          1: b = ~a;
          2: begin a = '1; b = r64[WIDTH-1:0]; end
          default: begin
            a = a | (48'hFFF << (12 * $urandom_range(0, 3)));
            b = 48'($urandom_range(1, 4));
          end
        endcase
        in_tag = TAG_W'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("final_drain", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
